wb_port_arbiter: RTL

- Arbitrates the single register-file write port between two requesters:
  - the pipeline write-back path, driven from the MEM/WB register outputs with the MemtoReg mux already applied;
  - a multi-cycle mul/div unit that returns results out of band.
- Mul/div results are buffered in a small FIFO.
- Pipeline has priority, but a starvation counter forces a FIFO drain and stalls the pipeline for that cycle.
- Sits between the MEM/WB register, the mul/div unit and the register file write port.

---
 rtl/wb_port_arbiter.sv | 125 ++++++++++++
 1 files changed

// File: rtl/wb_port_arbiter.sv
// Register-file write-port arbiter: pipeline write-back has priority, mul/div results
// queue in a small FIFO and are forced through after STARVE_MAX denied cycles.
module wb_port_arbiter #(
    parameter int DATA_W     = 64,
    parameter int FIFO_DEPTH = 2,
    parameter int STARVE_MAX = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              wb_valid,
    input  logic [4:0]        wb_rd,
    input  logic [DATA_W-1:0] wb_data,
    input  logic              md_valid,
    input  logic [4:0]        md_rd,
    input  logic [DATA_W-1:0] md_data,
    output logic              md_ready,
    output logic              pipe_stall,
    output logic              rf_we,
    output logic [4:0]        rf_waddr,
    output logic [DATA_W-1:0] rf_wdata
);

    localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CNT_W = PTR_W + 1;
    localparam int STV_W = $clog2(STARVE_MAX + 1);

    localparam logic [CNT_W-1:0] DEPTH_C  = CNT_W'(FIFO_DEPTH);
    localparam logic [STV_W-1:0] STARVE_C = STV_W'(STARVE_MAX);

    logic [DATA_W-1:0] data_mem_r [FIFO_DEPTH];
    logic [4:0]        rd_mem_r   [FIFO_DEPTH];
    logic [PTR_W-1:0]  wr_ptr_r;
    logic [PTR_W-1:0]  rd_ptr_r;
    logic [CNT_W-1:0]  count_r;
    logic [STV_W-1:0]  starve_cnt_r;

    logic              wb_req_s;
    logic              fifo_req_s;
    logic              starve_hit_s;
    logic              grant_md_s;
    logic              grant_wb_s;
    logic              enq_s;
    logic              deq_s;
    logic [STV_W-1:0]  starve_nxt_s;
    logic [CNT_W-1:0]  count_nxt_s;

    // Request qualification, grant decision and handshake outputs.
    always_comb begin
        wb_req_s     = wb_valid && (wb_rd != 5'd0);
        fifo_req_s   = (count_r != {CNT_W{1'b0}});
        starve_hit_s = (starve_cnt_r >= STARVE_C);
        grant_md_s   = fifo_req_s && (!wb_req_s || starve_hit_s);
        grant_wb_s   = wb_req_s && !grant_md_s;
        // Both handshake outputs are forced low while reset is held.
        pipe_stall   = reset && wb_req_s && grant_md_s;
        md_ready     = reset && (count_r < DEPTH_C);
        enq_s        = md_valid && md_ready && (md_rd != 5'd0);
        deq_s        = grant_md_s;
    end

    // Next-state values for the FIFO occupancy and the starvation counter.
    always_comb begin
        count_nxt_s  = count_r;
        starve_nxt_s = starve_cnt_r;
        case ({enq_s, deq_s})
            2'b10:   count_nxt_s = count_r + CNT_W'(1);
            2'b01:   count_nxt_s = count_r - CNT_W'(1);
            default: count_nxt_s = count_r;
        endcase
        if (grant_md_s || !fifo_req_s) begin
            starve_nxt_s = {STV_W{1'b0}};
        end else if (starve_cnt_r < STARVE_C) begin
            starve_nxt_s = starve_cnt_r + STV_W'(1);
        end else begin
            starve_nxt_s = starve_cnt_r;
        end
    end

    // FIFO storage, pointers, occupancy and starvation state.
    always_ff @(posedge clk) begin
        if (!reset) begin
            wr_ptr_r     <= {PTR_W{1'b0}};
            rd_ptr_r     <= {PTR_W{1'b0}};
            count_r      <= {CNT_W{1'b0}};
            starve_cnt_r <= {STV_W{1'b0}};
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                data_mem_r[i] <= {DATA_W{1'b0}};
                rd_mem_r[i]   <= 5'd0;
            end
        end else begin
            if (enq_s) begin
                data_mem_r[wr_ptr_r] <= md_data;
                rd_mem_r[wr_ptr_r]   <= md_rd;
                wr_ptr_r             <= wr_ptr_r + PTR_W'(1);
            end
            if (deq_s) begin
                rd_ptr_r <= rd_ptr_r + PTR_W'(1);
            end
            count_r      <= count_nxt_s;
            starve_cnt_r <= starve_nxt_s;
        end
    end

    // Registered write port; address and data hold when nothing is granted.
    always_ff @(posedge clk) begin
        if (!reset) begin
            rf_we    <= 1'b0;
            rf_waddr <= 5'd0;
            rf_wdata <= {DATA_W{1'b0}};
        end else begin
            rf_we <= grant_wb_s || grant_md_s;
            if (grant_md_s) begin
                rf_waddr <= rd_mem_r[rd_ptr_r];
                rf_wdata <= data_mem_r[rd_ptr_r];
            end else if (grant_wb_s) begin
                rf_waddr <= wb_rd;
                rf_wdata <= wb_data;
            end else begin
                rf_waddr <= rf_waddr;
                rf_wdata <= rf_wdata;
            end
        end
    end

endmodule
